// File: rtl/serial_adder.sv
// Bit-serial M-bit two's-complement adder with start/done handshake.
// One full-adder cell is reused over M cycles, LSB first.
module serial_adder #(
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] R,
    output logic         cout,
    output logic         C,
    output logic         N,
    output logic         V,
    output logic         Z
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [M-1:0]    a_sh_q, a_sh_d;
    logic [M-1:0]    b_sh_q, b_sh_d;
    logic [M-1:0]    sum_sh_q, sum_sh_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [M-1:0]    r_q, r_d;
    logic            cout_q, cout_d;
    logic            n_q, n_d;
    logic            v_q, v_d;
    logic            z_q, z_d;

    logic            s;
    logic            carry_nx;
    logic [M-1:0]    sum_nx;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        r_d      = r_q;
        cout_d   = cout_q;
        n_d      = n_q;
        v_d      = v_q;
        z_d      = z_q;

        s        = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_nx = (a_sh_q[0] & b_sh_q[0])
                 | (a_sh_q[0] & carry_q)
                 | (b_sh_q[0] & carry_q);
        sum_nx   = {s, sum_sh_q[M-1:1]};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_sh_d   = A;
                    b_sh_d   = B;
                    sa_d     = A[M-1];
                    sb_d     = B[M-1];
                    carry_d  = 1'b0;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                carry_d  = carry_nx;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_nx;
                cnt_d    = cnt_q + 1'b1;
                // Last bit step: results are taken from the next-state values.
                if (cnt_q == CW'(M - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    r_d     = sum_nx;
                    cout_d  = carry_nx;
                    n_d     = s;
                    v_d     = (sa_q == sb_q) && (s != sa_q);
                    z_d     = (sum_nx == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            r_q      <= '0;
            cout_q   <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            r_q      <= r_d;
            cout_q   <= cout_d;
            n_q      <= n_d;
            v_q      <= v_d;
            z_q      <= z_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign R    = r_q;
    assign cout = cout_q;
    assign C    = cout_q;
    assign N    = n_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule
